unidade_controle_exp4: RTL and testbench
========================================

Name: unidade_controle_exp4

Overview:
- Moore control unit that sits directly upstream of the counter/comparator datapath. It drives the datapath's zera/conta controls, plus a registra strobe for the play register.
- It consumes igual and fim from the datapath.
- It sequences one game round: clear, wait for a play, register it, compare it, then advance or finish.
- It contains an internal edge detector for the raw jogada button and, optionally, a play timeout.

Parameters:
TIMEOUT_CICLOS, 5000, cycles allowed in ESPERA before timeout; used only when TIMEOUT_EN is defined; must be >= 2.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset; has priority over every other input.
iniciar  input  1  start/restart request, level-sampled.
jogada  input  1  raw play-button level; the block edge-detects it internally.
igual  input  1  datapath comparator "equal" flag.
fim  input  1  datapath counter terminal-count flag (rco).
zera  output  1  clears the datapath counter and register (the datapath inverts it for the 163).
conta  output  1  counter enable (enp).
registra  output  1  one-cycle load strobe for the play register.
pronto  output  1  round finished.
acertou  output  1  round ended with all plays correct.
errou  output  1  round ended on a mismatch.
timeout  output  1  round ended by timeout; tied 0 when TIMEOUT_EN is undefined.
db_estado  output  4  current state code, for debug display.

Behaviour:
- One clock (clock). reset is synchronous and active-high: on a rising edge with reset=1, state <= INICIAL, jogada_d <= 0, timeout counter <= 0.
- Edge detector:
  - jogada_d is jogada registered one cycle.
  - jp = jogada & ~jogada_d: a one-cycle pulse per rising edge of jogada.
  - jp is honoured only in ESPERA. A held button produces exactly one jp.
- State codes:
  - INICIAL 0000, PREPARACAO 0001, ESPERA 0010, REGISTRA 0011
  - COMPARACAO 0100, PROXIMO 0101
  - FIM_ACERTOU 1010, FIM_ERROU 1110, FIM_TIMEOUT 1101
- Transitions (evaluated each rising edge when reset=0):
  - INICIAL: iniciar=1 -> PREPARACAO; else stay.
  - PREPARACAO: -> ESPERA unconditionally.
  - ESPERA: jp=1 -> REGISTRA; else stay. With TIMEOUT_EN, see Optional Feature.
  - REGISTRA: -> COMPARACAO.
  - COMPARACAO:
    - igual=0 -> FIM_ERROU
    - igual=1 & fim=1 -> FIM_ACERTOU
    - igual=1 & fim=0 -> PROXIMO
  - PROXIMO: -> ESPERA.
  - FIM_ACERTOU / FIM_ERROU / FIM_TIMEOUT: iniciar=1 -> PREPARACAO; else stay (result is held).
  - Any unused code -> INICIAL.
- Outputs are pure Moore, decoded from the state register only:
  - zera=1 in INICIAL and PREPARACAO.
  - registra=1 in REGISTRA.
  - conta=1 in PROXIMO, so exactly one count per correct non-final play.
  - pronto=1 in all FIM_* states.
  - acertou=1 only in FIM_ACERTOU; errou=1 only in FIM_ERROU; timeout=1 only in FIM_TIMEOUT.
  - db_estado = state code.
- Reset values: state INICIAL, so zera=1 and conta=registra=pronto=acertou=errou=timeout=0, db_estado=0000.
- Latency:
  - jp -> registra high on the next edge.
  - registra -> compare 1 cycle later.
  - Correct play -> conta pulse 2 cycles after registra.
- Boundary conditions:
  - iniciar in any state other than INICIAL/FIM_* is ignored.
  - reset mid-round aborts to INICIAL on the next edge, regardless of jp/iniciar.
  - fim is examined only in COMPARACAO. A count wrap (fim=1) with igual=0 ends in FIM_ERROU; a mismatch dominates.
  - A jogada rising edge that occurs outside ESPERA is lost; it is not queued.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CICLOS) is held at 0 outside ESPERA and increments each cycle in ESPERA.
  - When it equals TIMEOUT_CICLOS-1 and jp=0, the FSM goes to FIM_TIMEOUT.
  - If jp=1 on that same cycle, jp wins and the FSM goes to REGISTRA.
  - The counter restarts at 0 on every entry to ESPERA.
- Undefined: no counter; FIM_TIMEOUT is unreachable; timeout=0 constant; ESPERA waits indefinitely.

Test Plan:
- Reset held 2 cycles, then released, with iniciar=0 for 10 cycles -> db_estado=0000, zera=1, all other outputs 0 throughout.
- iniciar pulse; then 16 plays with igual=1, and fim=1 only on the 16th -> 15 conta pulses, 16 registra pulses, end in FIM_ACERTOU (1010), pronto=1, acertou=1.
- Start; 3 correct plays, then 4th play with igual=0 -> 3 conta pulses, state 1110, errou=1, pronto=1; a later iniciar -> PREPARACAO, zera=1 for 1 cycle.
- jogada held high for 20 cycles while in ESPERA -> exactly one registra pulse; FSM returns to ESPERA and waits for a new rising edge.
- reset asserted during REGISTRA -> INICIAL on the next edge; no conta pulse; pronto=0.
- TIMEOUT_EN with TIMEOUT_CICLOS=8: idle in ESPERA -> FIM_TIMEOUT (1101) after exactly 8 cycles in ESPERA, timeout=1. Repeat with jp on the 8th cycle -> REGISTRA.

Source files
------------

// File: rtl/unidade_controle_exp4.sv
// Moore control unit for one game round: clear, wait for a play, register, compare, advance/finish.
// Define TIMEOUT_EN to add a play timeout of TIMEOUT_CICLOS cycles in ESPERA.
module unidade_controle_exp4 #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       conta,
    output logic       registra,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL     = 4'b0000;
    localparam logic [3:0] PREPARACAO  = 4'b0001;
    localparam logic [3:0] ESPERA      = 4'b0010;
    localparam logic [3:0] REGISTRA    = 4'b0011;
    localparam logic [3:0] COMPARACAO  = 4'b0100;
    localparam logic [3:0] PROXIMO     = 4'b0101;
    localparam logic [3:0] FIM_ACERTOU = 4'b1010;
    localparam logic [3:0] FIM_ERROU   = 4'b1110;
    localparam logic [3:0] FIM_TIMEOUT = 4'b1101;

    if (TIMEOUT_CICLOS < 2) begin : g_param_invalido
        $error("TIMEOUT_CICLOS must be at least 2");
    end

    logic [3:0] estado;
    logic [3:0] proximo_estado;
    logic       jogada_d;
    logic       jp;
    logic       estourou;

    always_ff @(posedge clock) begin
        if (reset) begin
            jogada_d <= 1'b0;
        end else begin
            jogada_d <= jogada;
        end
    end

    // One pulse per rising edge of the button; a held button yields a single jp.
    assign jp = jogada & ~jogada_d;

`ifdef TIMEOUT_EN
    localparam int CONT_W = $clog2(TIMEOUT_CICLOS);
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(TIMEOUT_CICLOS - 1);

    logic [CONT_W-1:0] cont_espera;

    // Counts only while staying in ESPERA, so every entry into ESPERA starts from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_espera <= '0;
        end else if (estado == ESPERA && proximo_estado == ESPERA) begin
            cont_espera <= cont_espera + 1'b1;
        end else begin
            cont_espera <= '0;
        end
    end

    assign estourou = (estado == ESPERA) && (cont_espera == CONT_MAX);
    assign timeout  = (estado == FIM_TIMEOUT);
`else
    assign estourou = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    // A mismatch dominates a simultaneous terminal count; jp beats a same-cycle timeout.
    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:     proximo_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  proximo_estado = ESPERA;
            ESPERA: begin
                if (jp) begin
                    proximo_estado = REGISTRA;
                end else if (estourou) begin
                    proximo_estado = FIM_TIMEOUT;
                end else begin
                    proximo_estado = ESPERA;
                end
            end
            REGISTRA:    proximo_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    proximo_estado = FIM_ERROU;
                end else if (fim) begin
                    proximo_estado = FIM_ACERTOU;
                end else begin
                    proximo_estado = PROXIMO;
                end
            end
            PROXIMO:     proximo_estado = ESPERA;
            FIM_ACERTOU: proximo_estado = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   proximo_estado = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT: proximo_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     proximo_estado = INICIAL;
        endcase
    end

    assign zera      = (estado == INICIAL) || (estado == PREPARACAO);
    assign registra  = (estado == REGISTRA);
    assign conta     = (estado == PROXIMO);
    assign pronto    = (estado == FIM_ACERTOU) || (estado == FIM_ERROU) || (estado == FIM_TIMEOUT);
    assign acertou   = (estado == FIM_ACERTOU);
    assign errou     = (estado == FIM_ERROU);
    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_exp4.sv
// Scoreboard bench for unidade_controle_exp4: stimulus predicts when each registra/conta/result
// event must appear, and a monitor checks the DUT against those predictions.
module tb_unidade_controle_exp4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim;
    logic       zera;
    logic       conta;
    logic       registra;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    unidade_controle_exp4 #(.TIMEOUT_CICLOS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fim       (fim),
        .zera      (zera),
        .conta     (conta),
        .registra  (registra),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Number of rising edges seen so far; inputs set at a negedge are sampled at edge cycle+1.
    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    localparam int EV_REG     = 0;
    localparam int EV_CONTA   = 1;
    localparam int EV_ACERTOU = 2;
    localparam int EV_ERROU   = 3;
    localparam int EV_TIMEOUT = 4;

    // Flag order: {zera, conta, registra, pronto, acertou, errou, timeout}
    localparam logic [6:0] FL_NONE    = 7'b0000000;
    localparam logic [6:0] FL_ZERA    = 7'b1000000;
    localparam logic [6:0] FL_ACERTOU = 7'b0001100;
    localparam logic [6:0] FL_ERROU   = 7'b0001010;
    localparam logic [6:0] FL_TIMEOUT = 7'b0001001;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t expQ[$];
    int  nTests = 0;
    int  nFails = 0;
    int  countReg = 0;
    int  countConta = 0;
    int  espEntry = 0;

    function automatic logic [10:0] expSig(input int kind);
        case (kind)
            EV_REG:     return {4'b0011, 7'b0010000};
            EV_CONTA:   return {4'b0101, 7'b0100000};
            EV_ACERTOU: return {4'b1010, FL_ACERTOU};
            EV_ERROU:   return {4'b1110, FL_ERROU};
            default:    return {4'b1101, FL_TIMEOUT};
        endcase
    endfunction

    task automatic pushEv(input int kind, input int cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic ini, input logic jog, input logic ig, input logic fm);
        iniciar = ini;
        jogada  = jog;
        igual   = ig;
        fim     = fm;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expDb, input logic [6:0] expFl);
        logic [6:0] fl;
        fl = {zera, conta, registra, pronto, acertou, errou, timeout};
        nTests++;
        if (db_estado !== expDb || fl !== expFl) begin
            nFails++;
            $display("[TB] FAIL %s: got db_estado=%b flags=%b, expected db_estado=%b flags=%b",
                     name, db_estado, fl, expDb, expFl);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int expv);
        nTests++;
        if (got != expv) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: every registra, conta or new pronto must match the oldest predicted event.
    initial begin
        logic        prevPronto;
        logic [10:0] sig;
        ev_t         e;
        prevPronto = 1'b0;
        forever begin
            @(negedge clock);
            if (registra === 1'b1 || conta === 1'b1 || (pronto === 1'b1 && !prevPronto)) begin
                sig = {db_estado, zera, conta, registra, pronto, acertou, errou, timeout};
                if (registra === 1'b1) countReg++;
                if (conta === 1'b1) countConta++;
                nTests++;
                if (expQ.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL unexpected_event: got sig=%b at cycle %0d, expected no event",
                             sig, cycle);
                end else begin
                    e = expQ.pop_front();
                    if (sig !== expSig(e.kind) || cycle != e.cyc) begin
                        nFails++;
                        $display("[TB] FAIL event_kind%0d: got sig=%b at cycle %0d, expected sig=%b at cycle %0d",
                                 e.kind, sig, cycle, expSig(e.kind), e.cyc);
                    end
                end
            end
            prevPronto = (pronto === 1'b1);
        end
    end

    // Start a round from INICIAL or a FIM state; optionally keep iniciar high into ESPERA.
    task automatic startRound();
        logic again;
        again = 1'($urandom_range(1, 0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("preparacao", 4'b0001, FL_ZERA);
        espEntry = cycle + 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("espera_inicio", 4'b0010, FL_NONE);
        if (again) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clock);
            checkOutput("iniciar_ignorado", 4'b0010, FL_NONE);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One play from ESPERA; may hold the button or add a lost edge during COMPARACAO.
    task automatic pressOne(input logic ig, input logic fm, input int maxGap);
        int   gap;
        int   h;
        int   p;
        logic spur;
        gap  = int'($urandom_range(maxGap, 0));
        repeat (gap) @(negedge clock);
        h    = int'($urandom_range(3, 1));
        spur = (h == 1) && ($urandom_range(1, 0) == 1);
        p    = cycle + 1;
        applyStimulus(1'b0, 1'b1, ig, fm);
        pushEv(EV_REG, p);
        if (ig && !fm)  pushEv(EV_CONTA, p + 2);
        else if (ig)    pushEv(EV_ACERTOU, p + 2);
        else            pushEv(EV_ERROU, p + 2);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            if (e == 2) checkOutput("comparacao", 4'b0100, FL_NONE);
            applyStimulus(1'b0, (e < h) || (spur && e == 2), ig, fm);
        end
        @(negedge clock);
        if (ig && !fm) begin
            espEntry = p + 3;
            checkOutput("espera_apos_proximo", 4'b0010, FL_NONE);
        end else if (ig) begin
            checkOutput("fim_acertou_mantido", 4'b1010, FL_ACERTOU);
        end else begin
            checkOutput("fim_errou_mantido", 4'b1110, FL_ERROU);
        end
    endtask

    initial begin
        int r0;
        int c0;
        int p;
        int n;
        int mis;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("reset_ativo_1", 4'b0000, FL_ZERA);
        @(negedge clock);
        checkOutput("reset_ativo_2", 4'b0000, FL_ZERA);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            @(negedge clock);
            checkOutput("inicial_ocioso", 4'b0000, FL_ZERA);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        $display("[TB] full round: 16 correct plays");
        r0 = countReg;
        c0 = countConta;
        startRound();
        for (int i = 0; i < 16; i++) pressOne(1'b1, (i == 15), 3);
        checkCount("registra_16", countReg - r0, 16);
        checkCount("conta_15", countConta - c0, 15);

        $display("[TB] mismatch on 4th play");
        r0 = countReg;
        c0 = countConta;
        startRound();
        for (int i = 0; i < 3; i++) pressOne(1'b1, 1'b0, 3);
        pressOne(1'b0, 1'b0, 3);
        checkCount("registra_4", countReg - r0, 4);
        checkCount("conta_3", countConta - c0, 3);

        $display("[TB] mismatch with fim=1");
        startRound();
        pressOne(1'b0, 1'b1, 2);

        $display("[TB] button held 20 cycles");
        r0 = countReg;
        startRound();
        p = cycle + 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        pushEv(EV_REG, p);
        pushEv(EV_CONTA, p + 2);
`ifdef TIMEOUT_EN
        pushEv(EV_TIMEOUT, p + 11);
`endif
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 10) checkOutput("espera_botao_preso", 4'b0010, FL_NONE);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
`ifdef TIMEOUT_EN
        checkOutput("timeout_botao_preso", 4'b1101, FL_TIMEOUT);
        checkCount("registra_botao_preso", countReg - r0, 1);
`else
        checkOutput("espera_apos_soltar", 4'b0010, FL_NONE);
        espEntry = p + 3;
        pressOne(1'b1, 1'b1, 4);
        checkCount("registra_botao_preso", countReg - r0, 2);
`endif

        $display("[TB] reset during REGISTRA");
        c0 = countConta;
        startRound();
        p = cycle + 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        pushEv(EV_REG, p);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("reset_em_registra", 4'b0000, FL_ZERA);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("inicial_apos_reset", 4'b0000, FL_ZERA);
        checkCount("conta_apos_reset", countConta - c0, 0);

`ifdef TIMEOUT_EN
        $display("[TB] timeout idle and jp on last cycle");
        startRound();
        pushEv(EV_TIMEOUT, espEntry + 8);
        while (cycle < espEntry + 8) @(negedge clock);
        checkOutput("fim_timeout", 4'b1101, FL_TIMEOUT);
        startRound();
        while (cycle < espEntry + 7) @(negedge clock);
        pressOne(1'b1, 1'b0, 0);
        pressOne(1'b1, 1'b1, 2);
`endif

        $display("[TB] random rounds");
        for (int r = 0; r < 6; r++) begin
            startRound();
            n   = int'($urandom_range(16, 1));
            mis = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(n - 1, 0));
            for (int i = 0; i < n; i++) begin
                if (i == mis) begin
                    pressOne(1'b0, 1'($urandom_range(1, 0)), 4);
                    break;
                end else begin
                    pressOne(1'b1, (i == n - 1), 4);
                end
            end
        end

        for (int k = 0; k < 50 && expQ.size() > 0; k++) @(negedge clock);
        nTests++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL pending_events: got %0d outstanding, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
